truth_table_scanner: RTL and testbench

Sequential truth-table sweeper for a combinational function under test. It drives every input combination of an N-input boolean expression onto `x_out`, for example the `{x, y, z}` inputs of the `fxy` expression stage. It samples the single-bit function output back on `f_in` and assembles the full truth vector. It then compares that vector against an expected vector and reports match, the first mismatching minterm and the count of true minterms. It sits directly upstream and downstream of the expression block, replacing the hand-written stimulus lists used in the expression test benches.

---
 rtl/truth_table_scanner.sv | 131 +++++++++++++
 tb/tb_truth_table_scanner.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Sweeps every minterm of an N_IN-input function, captures its output per minterm,
// and reports match / first mismatching minterm / count of true minterms.
module truth_table_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f_in,
  output logic [N_IN-1:0]        x_out,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out,
  output logic                   match,
  output logic [N_IN-1:0]        mismatch_idx,
  output logic [N_IN:0]          ones_count
);

  localparam int NV = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NV - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [3:0]        wait_q, wait_d;
  logic [NV-1:0]     exp_q, exp_d;
  logic [NV-1:0]     table_q, table_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              match_q, match_d;
  logic [N_IN-1:0]   midx_q, midx_d;
  logic [N_IN:0]     ones_q, ones_d;

  function automatic logic [N_IN:0] popcount(input logic [NV-1:0] v);
    logic [N_IN:0] c;
    c = '0;
    for (int i = 0; i < NV; i++) c = c + {{N_IN{1'b0}}, v[i]};
    return c;
  endfunction

  // Scan from the top down so the lowest differing minterm wins.
  function automatic logic [N_IN-1:0] first_diff(input logic [NV-1:0] a,
                                                 input logic [NV-1:0] b);
    logic [N_IN-1:0] r;
    r = '0;
    for (int i = NV - 1; i >= 0; i--) if (a[i] != b[i]) r = N_IN'(i);
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    exp_d   = exp_q;
    table_d = table_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    match_d = match_q;
    midx_d  = midx_q;
    ones_d  = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          exp_d   = expected;
          table_d = '0;
          idx_d   = '0;
          wait_d  = '0;
          busy_d  = 1'b1;
        end
      end
      DRIVE: begin
        if (32'(wait_q) < SETTLE) begin
          wait_d = wait_q + 4'd1;
        end else begin
          table_d[idx_q] = f_in;
          wait_d         = '0;
          if (idx_q == LAST_IDX) state_d = CHECK;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      CHECK: begin
        match_d = (table_q == exp_q);
        midx_d  = first_diff(table_q, exp_q);
        ones_d  = popcount(table_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      exp_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      midx_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      midx_q  <= midx_d;
      ones_q  <= ones_d;
    end
  end

  assign x_out        = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign match        = match_q;
  assign mismatch_idx = midx_q;
  assign ones_count   = ones_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: default (3 inputs, SETTLE=1) and
// a 2-input, SETTLE=0 instance, each checked against a truth-table model.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start2, f1, f2;
  logic [7:0] exp1;
  logic [3:0] exp2;
  logic [2:0] x1, midx1;
  logic [3:0] ones1;
  logic [7:0] tbl1;
  logic       busy1, done1, match1;
  logic [1:0] x2, midx2;
  logic [2:0] ones2;
  logic [3:0] tbl2;
  logic       busy2, done2, match2;

  int          mode1 = 0, mode2 = 0;
  logic [15:0] rt1 = '0, rt2 = '0;
  int          checks = 0, errors = 0;
  int          cyc = 0;

  typedef struct {
    int          e0;
    int          lat;
    logic [15:0] tbl;
    bit          match;
    int          midx;
    int          ones;
  } item_t;

  item_t q1[$], q2[$];
  item_t h1, h2;
  bit    act1, act2, pd1, pd2;

  // Function under test: XOR of the two low inputs, constant 1, or a random table.
  function automatic bit fref(int mode, int idx, logic [15:0] rt);
    if (mode == 0)      return ((idx >> 1) % 2) != (idx % 2);
    else if (mode == 1) return 1'b1;
    else                return rt[idx % 16];
  endfunction

  function automatic item_t model(int nv, int settle, int mode, logic [15:0] rt,
                                  logic [15:0] ev, int e0);
    item_t it;
    it.tbl = '0;
    for (int i = 0; i < nv; i++) it.tbl[i] = fref(mode, i, rt);
    it.match = 1'b1;
    it.midx  = 0;
    for (int i = 0; i < nv; i++)
      if (it.tbl[i] != ev[i]) begin
        if (it.match) it.midx = i;
        it.match = 1'b0;
      end
    it.ones = $countones(it.tbl);
    it.lat  = nv * (settle + 1) + 1;
    it.e0   = e0;
    return it;
  endfunction

  assign f1 = fref(mode1, int'(x1), rt1);
  assign f2 = fref(mode2, int'(x2), rt2);

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) u_dut (
    .clk(clk), .reset(reset), .start(start1), .expected(exp1), .f_in(f1),
    .x_out(x1), .busy(busy1), .done(done1), .table_out(tbl1), .match(match1),
    .mismatch_idx(midx1), .ones_count(ones1));

  truth_table_scanner #(.N_IN(2), .SETTLE(0)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .expected(exp2), .f_in(f2),
    .x_out(x2), .busy(busy2), .done(done2), .table_out(tbl2), .match(match2),
    .mismatch_idx(midx2), .ones_count(ones2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_res(string tag, item_t h, int c, int tb, int m, int mi, int on);
    chk({tag, "_latency"}, c - h.e0, h.lat);
    chk({tag, "_table"}, tb, int'(h.tbl));
    chk({tag, "_match"}, m, int'(h.match));
    chk({tag, "_mismatch_idx"}, mi, h.midx);
    chk({tag, "_ones"}, on, h.ones);
  endtask

  function automatic int clampi(int v, int hi);
    return (v > hi) ? hi : v;
  endfunction

  // Monitor for the default instance
  always @(negedge clk) begin
    if (!reset) begin
      act1 = q1.size() > 0 && cyc >= q1[0].e0 && (cyc - q1[0].e0) < q1[0].lat;
      chk("busy1", int'(busy1), int'(act1));
      if (act1) chk("x_out1", int'(x1), clampi((cyc - q1[0].e0) / 2, 7));
      if (done1) begin
        chk("done1_width", int'(pd1), 0);
        chk("done1_has_item", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          h1 = q1.pop_front();
          check_res("d1", h1, cyc, int'(tbl1), int'(match1), int'(midx1), int'(ones1));
        end
      end
      pd1 = done1;
    end else pd1 = 1'b0;
  end

  // Monitor for the 2-input instance
  always @(negedge clk) begin
    if (!reset) begin
      act2 = q2.size() > 0 && cyc >= q2[0].e0 && (cyc - q2[0].e0) < q2[0].lat;
      chk("busy2", int'(busy2), int'(act2));
      if (act2) chk("x_out2", int'(x2), clampi(cyc - q2[0].e0, 3));
      if (done2) begin
        chk("done2_width", int'(pd2), 0);
        chk("done2_has_item", int'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          h2 = q2.pop_front();
          check_res("d2", h2, cyc, int'(tbl2), int'(match2), int'(midx2), int'(ones2));
        end
      end
      pd2 = done2;
    end else pd2 = 1'b0;
  end

  task automatic wait_cyc(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(int d);
    for (int n = 0; n < 100 && ((d == 1) ? q1.size() : q2.size()) != 0; n++) @(posedge clk);
    if (d == 1) begin
      chk("timeout1", q1.size(), 0);
      q1.delete();
    end else begin
      chk("timeout2", q2.size(), 0);
      q2.delete();
    end
  endtask

  task automatic do_sweep(int d, int mode, logic [15:0] rt, logic [15:0] ev);
    @(negedge clk);
    if (d == 1) begin
      mode1 = mode; rt1 = rt; exp1 = ev[7:0]; start1 = 1'b1;
      q1.push_back(model(8, 1, mode, rt, {8'h00, ev[7:0]}, cyc + 1));
    end else begin
      mode2 = mode; rt2 = rt; exp2 = ev[3:0]; start2 = 1'b1;
      q2.push_back(model(4, 0, mode, rt, {12'h000, ev[3:0]}, cyc + 1));
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    exp1 = 8'($urandom);
    exp2 = 4'($urandom);
    wait_empty(d);
  endtask

  initial begin
    item_t       it;
    logic [15:0] rt, ev;
    int          e;
    reset = 1'b0; start1 = 1'b0; start2 = 1'b0; exp1 = '0; exp2 = '0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x1", int'(x1), 0);        chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);  chk("rst_tbl1", int'(tbl1), 0);
    chk("rst_match1", int'(match1), 0); chk("rst_midx1", int'(midx1), 0);
    chk("rst_ones1", int'(ones1), 0);  chk("rst_busy2", int'(busy2), 0);
    chk("rst_tbl2", int'(tbl2), 0);    chk("rst_ones2", int'(ones2), 0);
    @(negedge clk) reset = 1'b0;

    do_sweep(1, 0, '0, 16'h66);
    do_sweep(1, 0, '0, 16'h67);
    do_sweep(1, 0, '0, 16'hE6);
    do_sweep(1, 1, '0, 16'hFF);

    for (int n = 0; n < 8; n++) begin
      rt = 16'($urandom);
      it = model(8, 1, 2, rt, 16'h0, 0);
      case ($urandom_range(0, 2))
        0:       ev = it.tbl;
        1:       ev = it.tbl ^ (16'h1 << $urandom_range(0, 7));
        default: ev = 16'($urandom);
      endcase
      do_sweep(1, 2, rt, ev);
    end

    // Asynchronous reset in the middle of a sweep
    @(negedge clk);
    mode1 = 0; exp1 = 8'h66; start1 = 1'b1;
    q1.push_back(model(8, 1, 0, '0, 16'h66, cyc + 1));
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_x1", int'(x1), 0);       chk("mid_rst_busy1", int'(busy1), 0);
    chk("mid_rst_tbl1", int'(tbl1), 0);   chk("mid_rst_done1", int'(done1), 0);
    chk("mid_rst_match1", int'(match1), 0); chk("mid_rst_midx1", int'(midx1), 0);
    chk("mid_rst_ones1", int'(ones1), 0);
    q1.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle_busy1", int'(busy1), 0);
    chk("post_rst_idle_x1", int'(x1), 0);
    do_sweep(1, 0, '0, 16'h66);

    // start held high, expected disturbed mid-sweep
    @(negedge clk);
    mode1 = 0; ev = 16'h66; exp1 = ev[7:0]; start1 = 1'b1; e = cyc + 1;
    q1.push_back(model(8, 1, 0, '0, ev, e));
    for (int k = 0; k < 3; k++) begin
      wait_cyc(e + 5);
      exp1 = 8'($urandom);
      wait_cyc(e + 17);
      if (k < 2) begin
        ev = (k == 0) ? 16'h99 : 16'h66;
        exp1 = ev[7:0];
        e = e + 18;
        q1.push_back(model(8, 1, 0, '0, ev, e));
      end else start1 = 1'b0;
    end
    wait_empty(1);
    repeat (3) @(posedge clk);

    do_sweep(2, 0, '0, 16'h6);
    for (int n = 0; n < 6; n++) begin
      rt = 16'($urandom);
      it = model(4, 0, 2, rt, 16'h0, 0);
      ev = ($urandom_range(0, 1) == 0) ? it.tbl : 16'($urandom);
      do_sweep(2, 2, rt, ev);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
